// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters.
// Grant is combinational; sum, carry and owner id are registered one cycle later.
module add_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_in1,
    input  logic [NREQ*WIDTH-1:0] req_in2,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_out,
    output logic                  rsp_carry,
    output logic [IDW-1:0]        ptr
);

    logic [IDW-1:0]    r_ptr;
    logic              r_vld_p1;
    logic [IDW-1:0]    r_id_p1;
    logic [WIDTH-1:0]  r_out_p1;
    logic              r_carry_p1;

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic              w_found;
    logic [IDW:0]      w_idx_ext;
    logic [IDW-1:0]    w_gid;
    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH:0]    w_sum;

    // Stage p0: rotate requests so the pointer sits at bit 0, then take the first set bit
    always_comb begin
        w_dbl     = {req_valid, req_valid} >> r_ptr;
        w_rot     = w_dbl[NREQ-1:0];
        w_found   = 1'b0;
        w_idx_ext = '0;
        if (!reset && !stall) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_found && w_rot[k]) begin
                    w_found   = 1'b1;
                    w_idx_ext = {1'b0, r_ptr} + (IDW+1)'(k);
                end
            end
        end
        if (w_idx_ext >= (IDW+1)'(NREQ)) begin
            w_idx_ext = w_idx_ext - (IDW+1)'(NREQ);
        end
        w_gid     = w_idx_ext[IDW-1:0];
        w_grant   = w_found ? (NREQ'(1) << w_gid) : '0;
        w_ptr_nxt = (w_gid == IDW'(NREQ-1)) ? '0 : w_gid + IDW'(1);
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_a = req_in1[i*WIDTH +: WIDTH];
                w_b = req_in2[i*WIDTH +: WIDTH];
            end
        end
        w_sum = {1'b0, w_a} + {1'b0, w_b};
    end

    // Stage p1: registered response; stall freezes everything, an idle cycle only clears valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_vld_p1   <= 1'b0;
            r_id_p1    <= '0;
            r_out_p1   <= '0;
            r_carry_p1 <= 1'b0;
        end else if (!stall) begin
            r_vld_p1 <= w_found;
            if (w_found) begin
                r_ptr      <= w_ptr_nxt;
                r_id_p1    <= w_gid;
                r_out_p1   <= w_sum[WIDTH-1:0];
                r_carry_p1 <= w_sum[WIDTH];
            end
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_vld_p1;
    assign rsp_id    = r_id_p1;
    assign rsp_out   = r_out_p1;
    assign rsp_carry = r_carry_p1;
    assign ptr       = r_ptr;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: grant order, sums/carry, stall hold, reset discard, idle hold.
module tb_add_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  stall;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_in1;
    logic [NREQ*WIDTH-1:0] req_in2;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_out;
    logic                  rsp_carry;
    logic [IDW-1:0]        ptr;

    int n_checks = 0;
    int n_fail   = 0;

    add_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_carry(rsp_carry), .ptr(ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_in1[i*WIDTH +: WIDTH] = a;
        req_in2[i*WIDTH +: WIDTH] = b;
    endtask

    // Advance through one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = 4'b1111;
        req_in1   = '0;
        req_in2   = '0;

        // Reset for two cycles, ready forced low even with all requests up
        #1;
        chk("ready_in_reset", req_ready, 4'b0000);
        tick();
        tick();
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_out", rsp_out, 0);
        chk("rst_carry", rsp_carry, 0);
        chk("rst_ptr", ptr, 0);

        // Single request on requester 0
        reset     = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 32'h0000_0004, 32'h0040_0000);
        #1;
        chk("single_ready", req_ready, 4'b0001);
        tick();
        chk("single_valid", rsp_valid, 1);
        chk("single_id", rsp_id, 0);
        chk("single_out", rsp_out, 32'h0040_0004);
        chk("single_carry", rsp_carry, 0);
        chk("single_ptr", ptr, 1);

        // Carry out and pointer wrap from requester 3
        req_valid = 4'b1000;
        set_op(3, 32'hFFFF_FFFF, 32'h0000_0001);
        #1;
        chk("carry_ready", req_ready, 4'b1000);
        tick();
        chk("carry_valid", rsp_valid, 1);
        chk("carry_id", rsp_id, 3);
        chk("carry_out", rsp_out, 32'h0000_0000);
        chk("carry_flag", rsp_carry, 1);
        chk("carry_ptr_wrap", ptr, 0);

        // All four valid for eight cycles: 0,1,2,3,0,1,2,3
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i * 256), 32'(i));
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            int e;
            e = c % 4;
            #1;
            chk("rr_ready", req_ready, 64'(4'b0001 << e));
            tick();
            chk("rr_valid", rsp_valid, 1);
            chk("rr_id", rsp_id, 64'(e));
            chk("rr_out", rsp_out, 64'(e * 257));
            chk("rr_carry", rsp_carry, 0);
            chk("rr_ptr", ptr, 64'((e + 1) % 4));
        end

        // Grant requester 2, then stall three cycles with everyone requesting
        req_valid = 4'b0100;
        #1;
        chk("pre_stall_ready", req_ready, 4'b0100);
        tick();
        chk("pre_stall_id", rsp_id, 2);
        chk("pre_stall_ptr", ptr, 3);
        stall     = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_ready", req_ready, 4'b0000);
            tick();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_id", rsp_id, 2);
            chk("stall_out", rsp_out, 32'h0000_0202);
            chk("stall_ptr", ptr, 3);
        end
        stall = 1'b0;
        #1;
        chk("post_stall_ready", req_ready, 4'b1000);
        tick();
        chk("post_stall_id", rsp_id, 3);
        chk("post_stall_out", rsp_out, 32'h0000_0303);
        chk("post_stall_ptr", ptr, 0);

        // Grant requester 1, then reset on the following cycle
        req_valid = 4'b0010;
        #1;
        chk("mid_ready", req_ready, 4'b0010);
        tick();
        chk("mid_id", rsp_id, 1);
        chk("mid_ptr", ptr, 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", req_ready, 4'b0000);
        tick();
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_out", rsp_out, 0);
        chk("mid_rst_id", rsp_id, 0);
        chk("mid_rst_ptr", ptr, 0);
        reset     = 1'b0;
        req_valid = 4'b0000;
        tick();
        chk("mid_no_ghost", rsp_valid, 0);

        // Produce 0x1234_5678, then idle five cycles
        req_valid = 4'b0001;
        set_op(0, 32'h1234_0000, 32'h0000_5678);
        tick();
        chk("idle_seed_out", rsp_out, 32'h1234_5678);
        req_valid = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("idle_ready", req_ready, 4'b0000);
            tick();
            chk("idle_valid", rsp_valid, 0);
            chk("idle_out", rsp_out, 32'h1234_5678);
            chk("idle_ptr", ptr, 1);
        end

        // Pointer order beats index: ptr=1 with 0 and 2 requesting grants 2, then 0
        req_valid = 4'b0101;
        set_op(2, 32'h0000_0010, 32'h0000_0020);
        set_op(0, 32'h8000_0000, 32'h8000_0001);
        #1;
        chk("order_ready_a", req_ready, 4'b0100);
        tick();
        chk("order_id_a", rsp_id, 2);
        chk("order_out_a", rsp_out, 32'h0000_0030);
        chk("order_ptr_a", ptr, 3);
        #1;
        chk("order_ready_b", req_ready, 4'b0001);
        tick();
        chk("order_id_b", rsp_id, 0);
        chk("order_out_b", rsp_out, 32'h0000_0001);
        chk("order_carry_b", rsp_carry, 1);
        chk("order_ptr_b", ptr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter and sequencer that time-shares one WIDTH-bit adder among NREQ requesters, for example PC+4, branch-target and address-offset generation in the multi-cycle datapath. Each cycle it grants at most one valid requester and samples that requester's operands. One cycle later it returns the registered sum, carry-out and requester id. A global stall freezes arbitration without losing the pending result.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand and result width in bits
- IDW, 3, requester-id width; must satisfy 2^IDW >= NREQ
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  when high: no grant, pointer and response registers hold
- req_valid  input  NREQ  bit i: requester i presents operands
- req_in1  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_in2  input  NREQ*WIDTH  operand B; same packing as req_in1
- req_ready  output  NREQ  one-hot or zero; combinational grant
- rsp_valid  output  1  registered; result present this cycle
- rsp_id  output  IDW  registered; index of the requester that owns the result
- rsp_out  output  WIDTH  registered; (in1 + in2) mod 2^WIDTH
- rsp_carry  output  1  registered; carry-out of the addition
- ptr  output  IDW  registered; current round-robin start index (debug)

## Operation
- Reset values: rsp_valid=0, rsp_id=0, rsp_out=0, rsp_carry=0, ptr=0. While reset is high, req_ready=0.
- Grant rule when stall=0 and reset=0:
  - Search indices ptr, ptr+1, … wrapping modulo NREQ.
  - Grant the first i with req_valid[i]=1, so req_ready[i]=1; all other bits are 0.
- No valid requesters: req_ready=0 and ptr holds.
- Handshake: a transfer occurs on a cycle where req_valid[i]&req_ready[i]=1. Operands are sampled only on that edge.
- A requester that is not granted must hold valid and operands stable until granted. The arbiter never drops a request.
- After a grant to i: ptr <= (i+1) mod NREQ. The wrap from NREQ-1 goes to 0.
- Arithmetic:
  - Perform a (WIDTH+1)-bit unsigned add of zero-extended operands.
  - rsp_out = low WIDTH bits; rsp_carry = MSB.
  - No signed overflow flag.
- Response update when stall=0:
  - If a transfer occurs, the next edge sets rsp_valid=1 and loads rsp_id, rsp_out and rsp_carry.
  - If no transfer occurs, the next edge sets rsp_valid=0, and rsp_id/rsp_out/rsp_carry hold their last values.
- Stall:
  - req_ready=0.
  - ptr, rsp_valid, rsp_id, rsp_out and rsp_carry hold, so a valid result stays presented for the whole stall.
- Reset mid-operation: a granted-but-unreturned result is discarded. Outputs take their reset values on the next edge.
- Requests asserted at the same time are resolved purely by pointer order. There is no fixed priority.

## Timing
- Grant latency: 0 cycles, combinational from req_valid, ptr, stall and reset.
- Result latency: 1 cycle. A transfer at edge N gives rsp_valid=1 from edge N to edge N+1.
- Throughput: one add per cycle. Back-to-back grants to different requesters are allowed.
- A requester continuously valid and alone gets granted every cycle.
- Fairness bound: a continuously valid requester is granted within NREQ cycles of non-stalled operation.
- There is no response backpressure. The consumer must capture rsp_* in the cycle rsp_valid=1, or keep stall asserted.

## Test plan
- Reset then single request: assert reset for 2 cycles, then req_valid=4'b0001 with in1=0x0000_0004 and in2=0x0040_0000.
  - Expected: req_ready=4'b0001 in the same cycle.
  - Next cycle: rsp_valid=1, rsp_id=0, rsp_out=0x0040_0004, rsp_carry=0, ptr=1.
- All four requesters valid for 8 cycles from ptr=0:
  - Expected grants in order 0,1,2,3,0,1,2,3.
  - rsp_id follows the same sequence delayed by 1 cycle.
- Carry and wrap-around: in1=0xFFFF_FFFF, in2=0x0000_0001 on requester 3.
  - Expected: rsp_out=0x0000_0000, rsp_carry=1, ptr wraps to 0.
- Stall:
  - Grant requester 2, then raise stall for 3 cycles while req_valid=4'b1111.
  - Expected: req_ready=0 for 3 cycles; rsp_valid=1 with requester 2's result held throughout; ptr=3 held.
  - After stall drops: requester 3 is granted first.
- Reset mid-operation: grant requester 1, then assert reset on the next cycle.
  - Expected: rsp_valid=0, rsp_out=0, ptr=0; the pending result never appears.
- Idle and hold: req_valid=0 for 5 cycles after a result 0x1234_5678.
  - Expected: rsp_valid=0, rsp_out stays 0x1234_5678, ptr unchanged, req_ready=0.
